// File: rtl/rs_dispatch.sv
// rs_dispatch - issue-side producer for the reservation-station bank.
//
// Takes one decoded instruction from the instruction queue into a one-entry
// hold register. It resolves both source operands from register-file status
// or from the CDB. In the cycle a ROB entry and an empty station are both
// available, it writes a complete reservation word into exactly one station.
// In that same cycle it pulses load_word and rob_alloc.
//
// Optional feature (compile-time macro):
//   RS_DISPATCH_RR_EN - round-robin station selection. The search starts just
//                       after the last station issued to. Without the macro
//                       the lowest-index empty station wins.
//
// res_out is a packed reservation word. Fields from MSB to LSB:
//   opcode[6:0], funct3[2:0], funct7, src1_tag, src2_tag,
//   src1_data[31:0], src2_data[31:0], src1_valid, src2_valid, rd_tag, pc[31:0]
// Total width is 109 + 3*TAG_W bits.

module rs_dispatch #(
  parameter int NUM_RS = 5,
  parameter int TAG_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_ip,
  // instruction queue
  input  logic                       iq_valid,
  output logic                       iq_ready,
  input  logic [6:0]                 iq_opcode,
  input  logic [2:0]                 iq_funct3,
  input  logic                       iq_funct7,
  input  logic [31:0]                iq_pc,
  input  logic [4:0]                 iq_rs1,
  input  logic [4:0]                 iq_rs2,
  input  logic [31:0]                iq_imm,
  input  logic                       iq_use_imm,
  // register file status
  output logic [4:0]                 rf_rs1,
  output logic [4:0]                 rf_rs2,
  input  logic                       rf_src1_valid,
  input  logic                       rf_src2_valid,
  input  logic [31:0]                rf_src1_data,
  input  logic [31:0]                rf_src2_data,
  input  logic [TAG_W-1:0]           rf_src1_tag,
  input  logic [TAG_W-1:0]           rf_src2_tag,
  // ROB / CDB
  input  logic [(1<<TAG_W)-1:0]      robs_calculated,
  input  logic [32*(1<<TAG_W)-1:0]   cdb_data,
  input  logic                       rob_alloc_ready,
  input  logic [TAG_W-1:0]           rob_tag,
  output logic                       rob_alloc,
  // reservation stations
  input  logic [NUM_RS-1:0]          res_empty,
  output logic [NUM_RS-1:0]          load_word,
  output logic [108+3*TAG_W:0]       res_out
);

  localparam int SEL_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam logic [6:0] S_OP_INVALID = 7'h00;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Instruction latched from the queue while it waits for a station and ROB entry.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
  } hold_t;

  // One resolved source operand.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } operand_t;

  // Reservation word as seen by the stations. Field order defines res_out.
  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] src1_tag;
    logic [TAG_W-1:0] src2_tag;
    logic [31:0]      src1_data;
    logic [31:0]      src2_data;
    logic             src1_valid;
    logic             src2_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      pc;
  } res_word_t;

  state_t                          state;
  hold_t                           hold;
  operand_t                        src1;
  operand_t                        src2;
  res_word_t                       res_word;
  logic [(1<<TAG_W)-1:0][31:0]     cdb_words;
  logic [SEL_W-1:0]                sel_idx;
  logic                            fire;
  logic                            capture;

  assign cdb_words = cdb_data;

  // Priority order: x0, immediate (src2 only), committed register value,
  // then a result already on the CDB. Otherwise wait on the producing tag.
  function automatic operand_t resolve(
    input logic [4:0]                  rs,
    input logic                        use_imm,
    input logic [31:0]                 imm,
    input logic                        rf_valid,
    input logic [31:0]                 rf_data,
    input logic [TAG_W-1:0]            rf_tag,
    input logic [(1<<TAG_W)-1:0]       calc,
    input logic [(1<<TAG_W)-1:0][31:0] cdb
  );
    operand_t op;
    op = '0;
    if (rs == 5'd0) begin
      op.valid = 1'b1;
    end else if (use_imm) begin
      op.valid = 1'b1;
      op.data  = imm;
    end else if (rf_valid) begin
      op.valid = 1'b1;
      op.data  = rf_data;
    end else if (calc[rf_tag]) begin
      op.valid = 1'b1;
      op.data  = cdb[rf_tag];
    end else begin
      op.tag   = rf_tag;
    end
    return op;
  endfunction

  // Handshake and issue conditions. Nothing moves during reset or flush.
  assign fire      = ~rst & (state == HOLD) & rob_alloc_ready & (|res_empty) & ~flush_ip;
  assign iq_ready  = ~rst & ~flush_ip & ((state == IDLE) | fire);
  assign capture   = iq_valid & iq_ready;
  assign rob_alloc = fire;
  assign rf_rs1    = hold.rs1;
  assign rf_rs2    = hold.rs2;

  // Re-resolve both operands every cycle, so a tag that completes during a
  // stall is picked up at issue.
  always_comb begin
    src1 = resolve(hold.rs1, 1'b0, 32'd0, rf_src1_valid, rf_src1_data,
                   rf_src1_tag, robs_calculated, cdb_words);
    src2 = resolve(hold.rs2, hold.use_imm, hold.imm, rf_src2_valid, rf_src2_data,
                   rf_src2_tag, robs_calculated, cdb_words);
  end

`ifdef RS_DISPATCH_RR_EN
  localparam int CW = SEL_W + 1;
  localparam logic [CW-1:0] NUM_RS_C = CW'(NUM_RS);

  logic [SEL_W-1:0] last_sel;
  logic [CW-1:0]    cand;

  // Round-robin pick: the first empty station after last_sel, wrapping.
  // The loop runs from the farthest offset to the nearest, so the nearest
  // empty station is the one that remains selected.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_RS; k >= 1; k--) begin
      cand = {1'b0, last_sel} + CW'(k);
      if (cand >= NUM_RS_C) cand = cand - NUM_RS_C;
      if (res_empty[cand[SEL_W-1:0]]) sel_idx = cand[SEL_W-1:0];
    end
  end

  // The last-issued pointer advances only when a word is actually written.
  // Its reset value makes the first search begin at station 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_sel <= SEL_W'(NUM_RS - 1);
    end else if (fire) begin
      last_sel <= sel_idx;
    end
  end
`else
  // Fixed priority: the lowest-index empty station wins. The loop runs
  // downward, so the last match it records is the lowest index.
  // NOTE: every always_comb output gets a default before any branch, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (res_empty[SEL_W'(i)]) sel_idx = SEL_W'(i);
    end
  end
`endif

  // One-hot load pulse to the selected station, only while issuing.
  always_comb begin
    load_word = '0;
    if (fire) load_word[sel_idx] = 1'b1;
  end

  // Build the reservation word. The bus stays all zero except on issue.
  always_comb begin
    res_word = '0;
    if (fire) begin
      res_word.opcode     = hold.opcode;
      res_word.funct3     = hold.funct3;
      res_word.funct7     = hold.funct7;
      res_word.src1_tag   = src1.tag;
      res_word.src2_tag   = src2.tag;
      res_word.src1_data  = src1.data;
      res_word.src2_data  = src2.data;
      res_word.src1_valid = src1.valid;
      res_word.src2_valid = src2.valid;
      res_word.rd_tag     = rob_tag;
      res_word.pc         = hold.pc;
    end
  end

  assign res_out = res_word;

  // IDLE/HOLD control and the hold register. Reset and flush both drop the
  // held instruction. A capture in the same cycle as an issue keeps the FSM
  // in HOLD, which allows one instruction per cycle.
  // NOTE: state is updated with non-blocking assignments, so every reader in
  // this clock edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst || flush_ip) begin
      state <= IDLE;
      // NOTE: the hold register is a single word, not an array. Clearing it
      // is cheap and makes rf_rs1/rf_rs2 deterministic out of reset.
      hold        <= '0;
      hold.opcode <= S_OP_INVALID;
    end else if (capture) begin
      state        <= HOLD;
      hold.opcode  <= iq_opcode;
      hold.funct3  <= iq_funct3;
      hold.funct7  <= iq_funct7;
      hold.pc      <= iq_pc;
      hold.rs1     <= iq_rs1;
      hold.rs2     <= iq_rs2;
      hold.imm     <= iq_imm;
      hold.use_imm <= iq_use_imm;
    end else if (fire) begin
      state <= IDLE;
    end
  end

endmodule
